ofdm_cp_inserter: RTL and testbench
===================================

// Module: ofdm_cp_inserter
// PURPOSE
//  Consumes the 64-point complex symbol stream (8-bit re/im, natural index order 0..63) on the OFDM datapath and
//  emits each symbol prefixed by its cyclic prefix: CP_LEN tail samples, then all N_FFT samples.
//  Two-bank ping-pong buffer: one bank fills while the other drains, so symbols can stream back-to-back.
// PARAMETERS
//  N_FFT   64  samples per symbol (power of 2)
//  CP_LEN  16  cyclic-prefix length, 1..N_FFT-1
//  DW      8   bits per real/imag component
// PORTS
//  clk        in   1       clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       input sample valid
//  in_ready   out  1       input can be accepted
//  in_re      in   DW      input real part
//  in_im      in   DW      input imag part
//  out_valid  out  1       output sample valid
//  out_ready  in   1       downstream accepts
//  out_re     out  DW      output real part
//  out_im     out  DW      output imag part
//  out_sop    out  1       first CP sample of a symbol
//  out_eop    out  1       last body sample (index N_FFT-1)
// BEHAVIOUR
//  - Reset (sync, high): both banks EMPTY, wr_bank=0, rd_bank=0, wr_idx=0, FSM=IDLE; out_valid/sop/eop=0,
//    out_re/out_im=0, in_ready=0 during reset, 1 the cycle after. Reset mid-symbol drops all partial/buffered data.
//  - Write: transfer on in_valid&&in_ready; sample stored at bank[wr_bank][wr_idx], wr_idx++.
//    Accepting wr_idx==N_FFT-1 marks the bank FULL, wrap wr_idx->0, toggle wr_bank.
//  - in_ready = (bank[wr_bank] != FULL). Both banks FULL -> in_ready=0.
//  - Read FSM: IDLE -> CP when bank[rd_bank] FULL; CP reads addr N_FFT-CP_LEN..N_FFT-1; BODY reads addr 0..N_FFT-1.
//    After BODY addr N_FFT-1 is loaded: bank[rd_bank]=EMPTY, toggle rd_bank, go to CP if the other bank is FULL,
//    else IDLE. No bubble between back-to-back symbols.
//  - Output register advances when !out_valid || out_ready; holds re/im/sop/eop stable while out_valid&&!out_ready.
//  - out_sop=1 with addr N_FFT-CP_LEN in CP; out_eop=1 with addr N_FFT-1 in BODY. 80 beats/symbol at defaults.
//  - Latency: out_valid rises on the 2nd posedge after the edge accepting input sample N_FFT-1 (empty pipeline).
//  - Simultaneous bank-full (write) and bank-release (read) on one edge: both take effect; a bank written to FULL and
//    released on one edge cannot occur (opposite banks).
//  - Data passes unmodified (no arithmetic); address counters are log2(N_FFT) bits and wrap.
// CONFIGURATION
//  CP_SYM_COUNT_EN defined: extra port sym_cnt out 16, counts symbols whose out_eop beat transferred
//    (out_valid&&out_ready&&out_eop); reset to 0; wraps 0xFFFF->0.
//  Not defined: port absent, no counter logic.
// STRUCTURE
//  Package ofdm_pkg: N_FFT, CP_LEN, DW defaults; ADDR_W=$clog2(N_FFT); rd_state_t enum {IDLE, CP, BODY};
//    bank_state_t enum {EMPTY, FULL}.
//  Sub-module cp_bank_ram: 2*N_FFT x 2*DW simple dual-port RAM (1 write, 1 async read port), address {bank, idx}.
//  Top: write counter, bank flags, read FSM, output register.
// TESTING
//  1 Ramp symbol in_re=0..63, in_im=63..0, out_ready=1 -> 80 beats: re 48..63 then 0..63, im 15..0 then 63..0;
//    sop on beat 0 (48,15), eop on beat 79 (63,0).
//  2 Three symbols streamed, in_valid=1 continuously -> 240 contiguous output beats, no gaps after first;
//    in_ready low only while both banks FULL.
//  3 out_ready toggled 1/0 every cycle and held low 20 cycles -> no sample lost/duplicated,
//    outputs stable while stalled.
//  4 reset pulsed after 30 input samples and again mid-CP output -> next cycle out_valid=0;
//    fresh symbol after reset emits correct 80 beats.
//  5 in_valid with random gaps (50%) -> output sequence identical to test 1.
//  6 CP_SYM_COUNT_EN defined, 5 symbols -> sym_cnt=5 after last eop transfer; 0 after reset.

Source files
------------

// File: rtl/ofdm_cp_inserter_pkg.sv
// Shared constants and state types for the OFDM cyclic-prefix inserter.
package ofdm_pkg;
    localparam int N_FFT  = 64;
    localparam int CP_LEN = 16;
    localparam int DW     = 8;
    localparam int ADDR_W = $clog2(N_FFT);

    typedef enum logic [1:0] {IDLE, CP, BODY} rd_state_t;
    typedef enum logic {EMPTY, FULL} bank_state_t;
endpackage

// File: rtl/ofdm_cp_inserter_if.sv
// Sample-stream bundle for the CP inserter: input stream plus CP-prefixed output stream.
interface ofdm_cp_inserter_if;
    import ofdm_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic          out_sop;
    logic          out_eop;

    // master is the surrounding datapath, slave is the inserter itself
    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_sop, out_eop
    );

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_sop, out_eop
    );
endinterface

// File: rtl/ofdm_cp_inserter_cp_bank_ram.sv
// Two-bank symbol store: one write port, one asynchronous read port, address {bank, idx}.
module cp_bank_ram
    import ofdm_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [2*DW-1:0]   wr_data,
    input  logic [ADDR_W:0]   rd_addr,
    output logic [2*DW-1:0]   rd_data
);
    logic [2*DW-1:0] mem [2*N_FFT];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/ofdm_cp_inserter.sv
// Ping-pong buffered cyclic-prefix inserter: emits CP_LEN tail samples then the full symbol.
// Optional symbol counter output sym_cnt is enabled by defining CP_SYM_COUNT_EN.
module ofdm_cp_inserter
    import ofdm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    ofdm_cp_inserter_if.slave  bus
`ifdef CP_SYM_COUNT_EN
    ,
    output logic [15:0]        sym_cnt
`endif
);
    localparam logic [ADDR_W-1:0] CP_START = ADDR_W'(N_FFT - CP_LEN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_FFT - 1);

    bank_state_t       bank_st [2];
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_addr_nxt;
    rd_state_t         rd_state;
    rd_state_t         rd_state_nxt;
    logic              wr_en;
    logic              wr_last;
    logic              advance;
    logic              load;
    logic              bank_release;
    logic [2*DW-1:0]   rd_data;

    assign bus.in_ready = !reset && (bank_st[wr_bank] != FULL);
    assign wr_en        = bus.in_valid && bus.in_ready;
    assign wr_last      = wr_en && (wr_idx == LAST_IDX);
    assign advance      = !bus.out_valid || bus.out_ready;
    assign load         = advance && (rd_state != IDLE);

    cp_bank_ram u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank, wr_idx}),
        .wr_data ({bus.in_re, bus.in_im}),
        .rd_addr ({rd_bank, rd_addr}),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx  <= '0;
            wr_bank <= 1'b0;
        end else if (wr_en) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_last) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Fill and release always target opposite banks, so both may land on one edge
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_last && (wr_bank == 1'(b))) begin
                    bank_st[b] <= FULL;
                end else if (bank_release && (rd_bank == 1'(b))) begin
                    bank_st[b] <= EMPTY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= IDLE;
            rd_addr  <= '0;
            rd_bank  <= 1'b0;
        end else begin
            rd_state <= rd_state_nxt;
            rd_addr  <= rd_addr_nxt;
            if (bank_release) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        rd_addr_nxt  = rd_addr;
        bank_release = 1'b0;
        case (rd_state)
            IDLE: begin
                if (bank_st[rd_bank] == FULL) begin
                    rd_state_nxt = CP;
                    rd_addr_nxt  = CP_START;
                end
            end
            CP: begin
                if (load) begin
                    rd_addr_nxt = rd_addr + 1'b1;
                    if (rd_addr == LAST_IDX) begin
                        rd_state_nxt = BODY;
                    end
                end
            end
            BODY: begin
                if (load) begin
                    rd_addr_nxt = rd_addr + 1'b1;
                    if (rd_addr == LAST_IDX) begin
                        bank_release = 1'b1;
                        // Chain straight into the next prefix to avoid a bubble
                        if (bank_st[~rd_bank] == FULL) begin
                            rd_state_nxt = CP;
                            rd_addr_nxt  = CP_START;
                        end else begin
                            rd_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: rd_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_sop   <= 1'b0;
            bus.out_eop   <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
        end else if (advance) begin
            bus.out_valid <= load;
            bus.out_sop   <= load && (rd_state == CP) && (rd_addr == CP_START);
            bus.out_eop   <= load && (rd_state == BODY) && (rd_addr == LAST_IDX);
            if (load) begin
                {bus.out_re, bus.out_im} <= rd_data;
            end
        end
    end

`ifdef CP_SYM_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.out_eop) begin
            sym_cnt <= sym_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Randomized self-checking bench for ofdm_cp_inserter against a queue-based symbol model.
// The sym_cnt checks are compiled in when CP_SYM_COUNT_EN is defined.
module tb_ofdm_cp_inserter;
    import ofdm_pkg::*;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          sop;
        logic          eop;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ofdm_cp_inserter_if bus();
`ifdef CP_SYM_COUNT_EN
    logic [15:0] sym_cnt;
`endif

    ofdm_cp_inserter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CP_SYM_COUNT_EN
        ,
        .sym_cnt (sym_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    beat_t         exp_q[$];
    beat_t         partial[$];
    int            pending_syms = 0;
    int            xfer_count = 0;
    int            first_xfer_cyc = 0;
    int            last_xfer_cyc = 0;
    int            accept_edge = 0;
    bit            lat_enable = 1'b0;
    bit            latency_armed = 1'b0;
    int            ready_mode = 0;
    logic [DW-1:0] sym_re [N_FFT];
    logic [DW-1:0] sym_im [N_FFT];
    beat_t         prev_beat = '0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic          prev_reset = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: each completed 64-sample symbol becomes its 16-sample tail then all 64 samples
    always @(negedge clk) begin : monitor
        beat_t cur;
        beat_t e;
        beat_t b;
        cur = {bus.out_re, bus.out_im, bus.out_sop, bus.out_eop};
        if (!prev_reset && prev_valid && !prev_ready) begin
            checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stall_hold", 32'(cur), 32'(prev_beat));
        end
        if (reset) begin
            exp_q.delete();
            partial.delete();
            pending_syms = 0;
            latency_armed = 1'b0;
        end else begin
            if (latency_armed && bus.out_valid && !prev_valid) begin
                checkOutput("latency_edges", 32'(cyc - accept_edge), 32'd2);
                latency_armed = 1'b0;
            end
            if (!bus.in_ready) begin
                checkOutput("in_ready_low_needs_two_full", 32'(pending_syms >= 2), 32'd1);
            end else begin
                checkOutput("in_ready_high_has_room", 32'(pending_syms <= 2), 32'd1);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(cur), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beat", 32'(cur), 32'(e));
                    if (e.eop) pending_syms--;
                end
                xfer_count++;
                if (xfer_count == 1) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
            end
            if (bus.in_valid && bus.in_ready) begin
                b = {bus.in_re, bus.in_im, 2'b00};
                partial.push_back(b);
                if (partial.size() == N_FFT) begin
                    for (int k = 0; k < CP_LEN; k++) begin
                        b = partial[N_FFT - CP_LEN + k];
                        b.sop = (k == 0);
                        exp_q.push_back(b);
                    end
                    for (int k = 0; k < N_FFT; k++) begin
                        b = partial[k];
                        b.eop = (k == N_FFT - 1);
                        exp_q.push_back(b);
                    end
                    partial.delete();
                    pending_syms++;
                    if (lat_enable) begin
                        accept_edge = cyc + 1;
                        latency_armed = 1'b1;
                        lat_enable = 1'b0;
                    end
                end
            end
        end
        prev_beat  = cur;
        prev_valid = bus.out_valid;
        prev_ready = bus.out_ready;
        prev_reset = reset;
    end

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic loadRamp();
        for (int i = 0; i < N_FFT; i++) begin
            sym_re[i] = DW'(i);
            sym_im[i] = DW'(N_FFT - 1 - i);
        end
    endtask

    task automatic loadRandom();
        for (int i = 0; i < N_FFT; i++) begin
            sym_re[i] = DW'($urandom);
            sym_im[i] = DW'($urandom);
        end
    endtask

    // Offers the first n_samples of the loaded symbol, idling in_valid gap_pct percent of cycles
    task automatic applyStimulus(input int n_samples, input int gap_pct);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < n_samples && guard < 3000) begin
            bus.in_valid = ($urandom_range(0, 99) >= 32'(gap_pct));
            bus.in_re    = sym_re[i];
            bus.in_im    = sym_im[i];
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready && !reset;
            @(posedge clk);
            #1;
            if (acc) i++;
            guard++;
        end
        if (i < n_samples) checkOutput("input_timeout", 32'(i), 32'(n_samples));
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || partial.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= budget) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_fields", 32'({bus.out_re, bus.out_im, bus.out_sop, bus.out_eop}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        repeat (2) @(posedge clk);
        #1;
        pulseReset();

        $display("[TB] single ramp symbol");
        ready_mode = 0;
        loadRamp();
        xfer_count = 0;
        lat_enable = 1'b1;
        applyStimulus(N_FFT, 0);
        waitDrain(500);
        checkOutput("t1_beats", 32'(xfer_count), 32'd80);
        checkOutput("t1_latency_seen", 32'(latency_armed), 32'd0);

        $display("[TB] three back-to-back symbols");
        xfer_count = 0;
        for (int s = 0; s < 3; s++) begin
            loadRandom();
            applyStimulus(N_FFT, 0);
        end
        waitDrain(1000);
        checkOutput("t2_beats", 32'(xfer_count), 32'd240);
        checkOutput("t2_contiguous", 32'(last_xfer_cyc - first_xfer_cyc), 32'd239);

        $display("[TB] toggling and stalled out_ready");
        xfer_count = 0;
        ready_mode = 1;
        fork
            begin
                loadRandom();
                applyStimulus(N_FFT, 0);
                loadRandom();
                applyStimulus(N_FFT, 0);
            end
            begin
                repeat (90) @(posedge clk);
                #1;
                ready_mode = 2;
                repeat (20) @(posedge clk);
                #1;
                ready_mode = 1;
            end
        join
        waitDrain(2000);
        ready_mode = 0;
        checkOutput("t3_beats", 32'(xfer_count), 32'd160);

        $display("[TB] reset mid-input and mid-prefix");
        loadRamp();
        applyStimulus(30, 0);
        pulseReset();
        xfer_count = 0;
        applyStimulus(N_FFT, 0);
        begin
            int n = 0;
            while (xfer_count < 5 && n < 500) begin
                @(posedge clk);
                #1;
                n++;
            end
            checkOutput("t4_reached_cp", 32'(xfer_count >= 5), 32'd1);
        end
        pulseReset();
        xfer_count = 0;
        loadRamp();
        applyStimulus(N_FFT, 0);
        waitDrain(500);
        checkOutput("t4_fresh_beats", 32'(xfer_count), 32'd80);

        $display("[TB] ramp with random input gaps");
        xfer_count = 0;
        loadRamp();
        applyStimulus(N_FFT, 50);
        waitDrain(500);
        checkOutput("t5_beats", 32'(xfer_count), 32'd80);

        $display("[TB] random data, random gaps, random out_ready");
        xfer_count = 0;
        ready_mode = 3;
        for (int s = 0; s < 3; s++) begin
            loadRandom();
            applyStimulus(N_FFT, 30);
        end
        waitDrain(3000);
        ready_mode = 0;
        checkOutput("t5b_beats", 32'(xfer_count), 32'd240);

`ifdef CP_SYM_COUNT_EN
        $display("[TB] symbol counter");
        pulseReset();
        checkOutput("sym_cnt_after_reset", 32'(sym_cnt), 32'd0);
        for (int s = 0; s < 5; s++) begin
            loadRandom();
            applyStimulus(N_FFT, 0);
        end
        waitDrain(2000);
        checkOutput("sym_cnt_five", 32'(sym_cnt), 32'd5);
        pulseReset();
        checkOutput("sym_cnt_cleared", 32'(sym_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
